// File: rtl/led_pattern_sequencer_pkg.sv
// Shared mode codes, frame lengths and the LED pattern lookup for the running-light sequencer.
package led_seq_pkg;

    localparam logic [1:0] MODE_SHR    = 2'd0;
    localparam logic [1:0] MODE_SHL    = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [3:0] LAST_SHR    = 4'd8;
    localparam logic [3:0] LAST_SHL    = 4'd8;
    localparam logic [3:0] LAST_FILL   = 4'd8;
    localparam logic [3:0] LAST_BOUNCE = 4'd13;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_t;

    function automatic logic [3:0] mode_last_idx(input logic [1:0] mode);
        logic [3:0] last;
        case (mode)
            MODE_SHR:  last = LAST_SHR;
            MODE_SHL:  last = LAST_SHL;
            MODE_FILL: last = LAST_FILL;
            default:   last = LAST_BOUNCE;
        endcase
        return last;
    endfunction

    // Every pattern blanks on its last step except BOUNCE, which walks back toward bit 7.
    function automatic logic [7:0] led_pattern(input logic [1:0] mode, input logic [3:0] idx);
        logic [7:0] pat;
        pat = 8'h00;
        case (mode)
            MODE_SHR:  if (idx < 4'd8) pat = 8'h80 >> idx;
            MODE_SHL:  if (idx < 4'd8) pat = 8'h01 << idx;
            MODE_FILL: if (idx < 4'd8) pat = ~(8'hFF >> (idx + 4'd1));
            default: begin
                if (idx < 4'd8)       pat = 8'h80 >> idx;
                else if (idx < 4'd14) pat = 8'h01 << (idx - 4'd7);
            end
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Mode request channel between the board controls and the sequencer.
interface led_pattern_sequencer_if;
    // Valid/ready: a transfer happens on a rising Clk when ModeValid and ModeReady are both high;
    // the requester holds ModeValid and Mode stable until it sees ModeReady.
    logic [1:0] Mode;
    logic       ModeValid;
    logic       ModeReady;

    modport master (output Mode, output ModeValid, input ModeReady);
    modport slave  (input Mode, input ModeValid, output ModeReady);
endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Step prescaler: one Tick every CLK_DIV enabled cycles; the count freezes while En is low.
module led_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic Clk,
    input  logic RST_n,
    input  logic En,
    output logic Tick
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign Tick   = En & w_wrap;

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            r_cnt <= '0;
        end else if (En) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// Running-light sequencer: steps the current pattern on each tick and swaps modes only at frame boundaries.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                    Clk,
    input  logic                    RST_n,
    input  logic                    En,
    led_pattern_sequencer_if.slave  mode_if,
    output logic [7:0]              LED,
    output logic                    FrameDone,
    output logic [1:0]              CurMode,
    output seq_state_t              DbgState
);
    seq_state_t r_state;
    seq_state_t w_state_next;

    logic [1:0] r_cur_mode;
    logic [3:0] r_idx;
    logic       r_pend_valid;
    logic [1:0] r_pend_mode;
    logic [7:0] r_led;
    logic       r_frame_done;

    logic       w_tick;
    logic       w_last;
    logic       w_xfer;
    logic       w_boundary;
    logic [1:0] w_next_mode;
    logic [3:0] w_next_idx;
    logic [7:0] w_next_led;

    led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .Clk  (Clk),
        .RST_n(RST_n),
        .En   (En),
        .Tick (w_tick)
    );

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    // A request landing on the boundary cycle bypasses the slot and takes effect immediately.
    always_comb begin
        w_state_next = r_state;
        w_last       = (r_idx == mode_last_idx(r_cur_mode));
        w_xfer       = mode_if.ModeValid & ~r_pend_valid;
        w_boundary   = 1'b0;
        w_next_mode  = r_cur_mode;
        w_next_idx   = r_idx;
        w_next_led   = r_led;

        w_state_next = En ? ST_RUN : ST_HOLD;

        if (r_pend_valid)  w_next_mode = r_pend_mode;
        else if (w_xfer)   w_next_mode = mode_if.Mode;

        if (w_tick) begin
            if (w_last) begin
                w_boundary = 1'b1;
                w_next_idx = 4'd0;
                w_next_led = led_pattern(w_next_mode, 4'd0);
            end else begin
                w_next_idx = r_idx + 4'd1;
                w_next_led = led_pattern(r_cur_mode, r_idx + 4'd1);
            end
        end
    end

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            r_cur_mode   <= MODE_SHR;
            r_idx        <= 4'd0;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= MODE_SHR;
            r_led        <= 8'h80;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            r_idx        <= w_next_idx;
            r_led        <= w_next_led;
            if (w_boundary) begin
                r_cur_mode   <= w_next_mode;
                r_pend_valid <= 1'b0;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b1;
                r_pend_mode  <= mode_if.Mode;
            end
        end
    end

    assign mode_if.ModeReady = ~r_pend_valid;
    assign LED               = r_led;
    assign FrameDone         = r_frame_done;
    assign CurMode           = r_cur_mode;
    assign DbgState          = r_state;
endmodule
